// File: rtl/neuron_seq.sv
// Sequential neuron: multiply-accumulates N_IN (activation, weight) pairs, adds a bias,
// then produces a piecewise-linear sigmoid activation and its derivative.
module neuron_seq #(
    parameter int N_IN = 32,
    parameter int DW   = 32,
    parameter int FRAC = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] bias,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] prev_activ,
    input  logic [DW-1:0] weight,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] activ,
    output logic [DW-1:0] sigma_prime,
    output logic          busy
);

    localparam int AW = DW + $clog2(N_IN) + 1;
    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CW-1:0] LAST_PAIR = CW'(N_IN - 1);

    localparam logic [DW:0] ONE_W  = (DW+1)'(1) << FRAC;
    localparam logic [DW:0] FIVE   = (DW+1)'(5) << FRAC;
    localparam logic [DW:0] KNEE   = (DW+1)'(19) << (FRAC - 3);
    localparam logic [DW:0] OFS_HI = (DW+1)'(27) << (FRAC - 5);
    localparam logic [DW:0] OFS_MD = (DW+1)'(5) << (FRAC - 3);
    localparam logic [DW:0] OFS_LO = (DW+1)'(1) << (FRAC - 1);

    localparam logic signed [DW-1:0] ONE_D = DW'(ONE_W);
    localparam logic signed [DW-1:0] XMAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] XMIN  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACCUM, ACT, DERIV, OUT} state_t;

    state_t               state, next_state;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;
    logic signed [DW-1:0] bias_q;
    logic signed [DW-1:0] activ_q;
    logic signed [DW-1:0] sigma_q;
    logic                 accept;

    // Full-precision product scaled back to FRAC fractional bits (floor).
    function automatic logic signed [AW-1:0] mac_term(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] w);
        logic signed [2*DW-1:0] pa, pw, prod;
        pa   = (2*DW)'(a);
        pw   = (2*DW)'(w);
        prod = pa * pw;
        return AW'(prod >>> FRAC);
    endfunction

    function automatic logic signed [DW-1:0] saturate(input logic signed [AW-1:0] a,
                                                      input logic signed [DW-1:0] b);
        logic signed [AW:0] s;
        s = (AW+1)'(a) + (AW+1)'(b);
        if ((&s[AW:DW-1]) || !(|s[AW:DW-1]))
            return s[DW-1:0];
        else if (s[AW])
            return XMIN;
        else
            return XMAX;
    endfunction

    // Evaluated on |x| and mirrored for negative x, so the curve is point-symmetric about 0.5.
    function automatic logic signed [DW-1:0] sigmoid(input logic signed [DW-1:0] x);
        logic [DW:0] ax, y_abs;
        ax = x[DW-1] ? ({1'b0, ~x} + {{DW{1'b0}}, 1'b1}) : {1'b0, x};
        if (ax >= FIVE)
            y_abs = ONE_W;
        else if (ax >= KNEE)
            y_abs = (ax >> 5) + OFS_HI;
        else if (ax >= ONE_W)
            y_abs = (ax >> 3) + OFS_MD;
        else
            y_abs = (ax >> 2) + OFS_LO;
        return x[DW-1] ? DW'(ONE_W - y_abs) : DW'(y_abs);
    endfunction

    function automatic logic signed [DW-1:0] deriv(input logic signed [DW-1:0] y);
        logic signed [DW-1:0]   om;
        logic signed [2*DW-1:0] pa, pb, prod;
        om   = ONE_D - y;
        pa   = (2*DW)'(y);
        pb   = (2*DW)'(om);
        prod = pa * pb;
        return DW'(prod >>> FRAC);
    endfunction

    assign accept = (state == ACCUM) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACCUM;
            ACCUM:   if (accept && (cnt == LAST_PAIR)) next_state = ACT;
            ACT:     next_state = DERIV;
            DERIV:   next_state = OUT;
            OUT:     if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            bias_q  <= '0;
            activ_q <= '0;
            sigma_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        cnt    <= '0;
                        bias_q <= $signed(bias);
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + mac_term($signed(prev_activ), $signed(weight));
                        cnt <= (cnt == LAST_PAIR) ? '0 : cnt + 1'b1;
                    end
                end
                ACT:     activ_q <= sigmoid(saturate(acc, bias_q));
                DERIV:   sigma_q <= deriv(activ_q);
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == ACCUM);
    assign out_valid   = (state == OUT);
    assign busy        = (state != IDLE);
    assign activ       = activ_q;
    assign sigma_prime = sigma_q;

endmodule

// File: tb/tb_neuron_seq.sv
// Directed + randomized bench for neuron_seq with an arithmetic reference model of the neuron.
module tb_neuron_seq;

    localparam int N = 32;
    localparam longint ONE  = 64'sd16777216;
    localparam longint XMAX = 64'sd2147483647;
    localparam longint XMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] prev_activ;
    logic [31:0] weight;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] activ;
    logic [31:0] sigma_prime;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic signed [31:0] av [N];
    logic signed [31:0] wv [N];

    neuron_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bias       (bias),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .prev_activ (prev_activ),
        .weight     (weight),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .activ      (activ),
        .sigma_prime(sigma_prime),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sig_ref(input longint x);
        longint ax, y;
        ax = (x < 0) ? -x : x;
        if (ax >= 5 * ONE)           y = ONE;
        else if (8 * ax >= 19 * ONE) y = ax / 32 + (27 * ONE) / 32;
        else if (ax >= ONE)          y = ax / 8 + (5 * ONE) / 8;
        else                         y = ax / 4 + ONE / 2;
        return (x < 0) ? ONE - y : y;
    endfunction

    function automatic void model(input logic [31:0] b, output longint ya, output longint ys);
        longint s;
        s = 0;
        for (int i = 0; i < N; i++)
            s += (longint'(av[i]) * longint'(wv[i])) >>> 24;
        s += longint'($signed(b));
        if (s > XMAX) s = XMAX;
        if (s < XMIN) s = XMIN;
        ya = sig_ref(s);
        ys = (ya * (ONE - ya)) >>> 24;
    endfunction

    task automatic fill_zero();
        for (int i = 0; i < N; i++) begin
            av[i] = '0;
            wv[i] = '0;
        end
    endtask

    task automatic fill_rand(input int k);
        logic signed [31:0] t;
        for (int i = 0; i < N; i++) begin
            t = $urandom; av[i] = t >>> k;
            t = $urandom; wv[i] = t >>> k;
        end
    endtask

    // One full evaluation: start, feed all pairs (optional gaps), check latency, hold, handshake.
    task automatic run_eval(input string tag, input logic [31:0] b, input int gap_pct,
                            input int hold, input bit poke_start,
                            output logic [31:0] obs_a, output logic [31:0] obs_s);
        longint ya, ys;
        int lat;
        model(b, ya, ys);
        @(negedge clk);
        start = 1'b1;
        bias  = b;
        @(negedge clk);
        start = 1'b0;
        bias  = $urandom;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                in_valid   = 1'b0;
                prev_activ = $urandom;
                weight     = $urandom;
                start      = poke_start;
                @(negedge clk);
                start = 1'b0;
            end
            in_valid   = 1'b1;
            prev_activ = av[i];
            weight     = wv[i];
            check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        obs_a = activ;
        obs_s = sigma_prime;
        start = poke_start;
        for (int h = 0; h <= hold; h++) begin
            check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_activ"}, 64'(activ), ya);
            check({tag, "_sigma"}, 64'(sigma_prime), ys);
            if (h < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_done_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_done_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rs;
        logic [31:0] edge_bias [9];
        logic signed [31:0] t;

        rst_n      = 1'b0;
        start      = 1'b0;
        bias       = '0;
        in_valid   = 1'b0;
        prev_activ = '0;
        weight     = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_activ", 64'(activ), 64'd0);
        check("rst_sigma", 64'(sigma_prime), 64'd0);
        rst_n = 1'b1;

        fill_zero();
        run_eval("zero", 32'h0000_0000, 0, 0, 1'b0, ra, rs);
        check("zero_activ_k", 64'(ra), 64'h0080_0000);
        check("zero_sigma_k", 64'(rs), 64'h0040_0000);

        av[0] = 32'sh0100_0000;
        wv[0] = 32'sh0100_0000;
        run_eval("unit", 32'h0000_0000, 0, 0, 1'b0, ra, rs);
        check("unit_activ_k", 64'(ra), 64'h00C0_0000);
        check("unit_sigma_k", 64'(rs), 64'h0030_0000);

        fill_zero();
        run_eval("pos8", 32'h0800_0000, 0, 0, 1'b0, ra, rs);
        check("pos8_activ_k", 64'(ra), 64'h0100_0000);
        check("pos8_sigma_k", 64'(rs), 64'h0);
        run_eval("neg8", 32'hF800_0000, 0, 0, 1'b0, ra, rs);
        check("neg8_activ_k", 64'(ra), 64'h0);
        check("neg8_sigma_k", 64'(rs), 64'h0);

        for (int i = 0; i < N; i++) begin
            av[i] = 32'sh0A00_0000;
            wv[i] = 32'sh0A00_0000;
        end
        run_eval("sat", 32'h0000_0000, 0, 0, 1'b0, ra, rs);
        check("sat_activ_k", 64'(ra), 64'h0100_0000);
        check("sat_sigma_k", 64'(rs), 64'h0);

        edge_bias = '{32'h0100_0000, 32'hFF00_0000, 32'h0260_0000, 32'h025F_FFFF,
                      32'h0500_0000, 32'h04FF_FFFF, 32'hFB00_0000, 32'h8000_0000,
                      32'h00FF_FFFF};
        fill_zero();
        for (int e = 0; e < 9; e++)
            run_eval("edge", edge_bias[e], 0, 0, 1'b0, ra, rs);

        for (int r = 0; r < 6; r++) begin
            fill_rand((r % 2 == 1) ? 5 : 7);
            t = $urandom;
            run_eval("rand", 32'(t >>> 5), 30, (r == 0) ? 10 : 2, 1'b1, ra, rs);
        end

        fill_rand(7);
        @(negedge clk);
        start = 1'b1;
        bias  = $urandom;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid   = 1'b1;
            prev_activ = av[i];
            weight     = wv[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_activ", 64'(activ), 64'd0);
        check("mid_rst_sigma", 64'(sigma_prime), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);

        fill_zero();
        run_eval("after_rst", 32'h0000_0000, 0, 0, 1'b0, ra, rs);
        check("after_rst_activ_k", 64'(ra), 64'h0080_0000);
        check("after_rst_sigma_k", 64'(rs), 64'h0040_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
